mem_access_controller: RTL
==========================

# mem_access_controller

Sequencer for the MEM stage of the five-stage pipeline: turns the single-cycle MemRead/MemWrite intent from the EX/MEM register into a req/ack transaction on a variable-latency data memory. Holds the upstream pipeline (PC through EX/MEM) with a stall while the transaction is outstanding. Inserts bubbles into the MEM/WB register so no write-back fires early. Delivers registered read data to MEM/WB once the transaction completes.

## Interface
- TIMEOUT_CYCLES, 16: max ACCESS cycles without Mem_Ack before forced completion (2..255)
- Clk  in  1  pipeline clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- MemRead_MEM  in  1  load in MEM stage
- MemWrite_MEM  in  1  store in MEM stage (priority over MemRead_MEM if both high)
- ALU_Result_MEM  in  32  byte address
- Write_Data_MEM  in  32  store data
- Mem_Req  out  1  memory request, registered
- Mem_We  out  1  1 = write, registered
- Mem_Addr  out  32  registered address
- Mem_Wdata  out  32  registered store data
- Mem_Ack  in  1  one-cycle completion pulse from memory
- Mem_Rdata  in  32  read data, valid with Mem_Ack
- Read_Data_MEM  out  32  registered load result to MEM/WB
- Stall_MEM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- Bubble_WB  out  1  force RegWrite/MemtoReg low into MEM/WB
- Timeout_Err  out  1  sticky timeout flag

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Access = MemRead_MEM | MemWrite_MEM.
  - If Access: latch Mem_Addr, Mem_Wdata, Mem_We = MemWrite_MEM; set Mem_Req = 1; clear the timeout counter; go to ACCESS.
- ACCESS:
  - Mem_Req, Mem_We, Mem_Addr and Mem_Wdata stay stable.
  - Counter increments each cycle.
  - On Mem_Ack: if !Mem_We, Read_Data_MEM <= Mem_Rdata; Mem_Req <= 0; go to DONE.
  - Else if counter == TIMEOUT_CYCLES-1: Timeout_Err <= 1; if !Mem_We, Read_Data_MEM <= 0; Mem_Req <= 0; go to DONE.
- DONE:
  - Stall released; the completed instruction advances into MEM/WB at the end of this cycle.
  - MemRead_MEM/MemWrite_MEM still describe the completed instruction and are ignored.
  - Always go to IDLE.
- Stall_MEM (combinational) = (IDLE & Access) | ACCESS. Bubble_WB = Stall_MEM.
- Mem_Ack outside ACCESS is ignored.
- A store leaves Read_Data_MEM unchanged.
- Timeout_Err is cleared only by reset.
- Instructions with no memory access pass through IDLE with no stall and no bus activity.

## Timing
- Reset (Rst_n low, asynchronous):
  - State = IDLE.
  - Mem_Req, Mem_We, Mem_Addr, Mem_Wdata, Read_Data_MEM, counter and Timeout_Err = 0.
  - Stall_MEM and Bubble_WB are forced 0 while Rst_n is low.
- Minimum latency:
  - Access seen in IDLE at cycle T; Mem_Req high from T+1.
  - Ack at T+1 gives DONE at T+2; Stall_MEM is high during T and T+1.
  - MEM/WB captures Read_Data_MEM at the end of T+2.
- General: Stall cycles = 1 + ACCESS cycles. ACCESS lasts from 1 cycle up to TIMEOUT_CYCLES cycles.
- Ack and timeout in the same cycle: ack wins; no Timeout_Err, real data captured.
- Back-to-back memory instructions: the second is seen in IDLE the cycle after DONE. Throughput is one access per 3 cycles at best.
- Reset during ACCESS: Mem_Req drops asynchronously, and the transaction is abandoned. A late Mem_Ack after reset is ignored.

## Test plan
- Load, ack 1 cycle after Mem_Req (ALU_Result_MEM = 0x100, Mem_Rdata = 0xCAFEF00D) -> Mem_Req at T+1 with Mem_Addr = 0x100 and Mem_We = 0; Stall_MEM high T..T+1; Read_Data_MEM = 0xCAFEF00D in DONE at T+2; Bubble_WB low at T+2.
- Store with ack after 5 cycles (addr 0x200, data 0x12345678) -> Mem_We = 1 and Mem_Wdata = 0x12345678 stable for 5 ACCESS cycles; 6 stall cycles; Read_Data_MEM unchanged.
- Load, no ack, TIMEOUT_CYCLES = 4 -> ACCESS lasts 4 cycles; Timeout_Err = 1 from DONE onward; Read_Data_MEM = 0; Mem_Req low in DONE; later accesses still complete normally.
- Two consecutive loads, and a stray Mem_Ack pulsed in IDLE and DONE -> two separate transactions with no duplicate issue in DONE; the stray ack changes nothing.
- Rst_n asserted during ACCESS -> Mem_Req, Stall_MEM and all registered outputs drop to 0 immediately; after release, state is IDLE; an ack arriving after reset is ignored.
- MemRead_MEM and MemWrite_MEM both high -> single write transaction (Mem_We = 1).

Source files
------------

// File: rtl/mem_access_controller.sv
// MEM-stage sequencer: turns a one-cycle load/store intent into a req/ack
// transaction on a variable-latency data memory, stalling the pipeline meanwhile.
module mem_access_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [31:0] ALU_Result_MEM,
  input  logic [31:0] Write_Data_MEM,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_Wdata,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_Rdata,
  output logic [31:0] Read_Data_MEM,
  output logic        Stall_MEM,
  output logic        Bubble_WB,
  output logic        Timeout_Err
);

  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DataW-1:0]  addr_q, addr_d;
  logic [DataW-1:0]  wdata_q, wdata_d;
  logic [DataW-1:0]  rdata_q, rdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              access_c;

  assign access_c = MemRead_MEM | MemWrite_MEM;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (access_c) begin
          addr_d  = ALU_Result_MEM;
          wdata_d = Write_Data_MEM;
          we_d    = MemWrite_MEM;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CntW'(1);
        // Ack takes precedence over a timeout landing in the same cycle
        if (Mem_Ack) begin
          if (!we_q) rdata_d = Mem_Rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          err_d = 1'b1;
          if (!we_q) rdata_d = '0;
          req_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Stall is combinational so the access is held in the very cycle it is seen
  assign Stall_MEM     = Rst_n & (((state_q == IDLE) & access_c) | (state_q == ACCESS));
  assign Bubble_WB     = Stall_MEM;
  assign Mem_Req       = req_q;
  assign Mem_We        = we_q;
  assign Mem_Addr      = addr_q;
  assign Mem_Wdata     = wdata_q;
  assign Read_Data_MEM = rdata_q;
  assign Timeout_Err   = err_q;

endmodule
